// File: rtl/prm_oblgc_pkg.sv
// rtl/prm_oblgc_pkg.sv - shared types and constants for the PRM obstacle-logic checker sequencer
package prm_oblgc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } oblgc_state_e;

  localparam int PRM_VEC_W   = 15;
  localparam int PRM_NUM_CHK = 64;

endpackage

// File: rtl/prm_rr_arb.sv
// rtl/prm_rr_arb.sv - round-robin arbiter, one-hot grant plus encoded id, search starts at ptr
module prm_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  logic [ID_W-1:0] k;

  always_comb begin
    gnt = '0;
    id  = '0;
    any = 1'b0;
    k   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (en && !any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        id     = k;
      end
    end
  end

endmodule

// File: rtl/prm_oblgc_sched.sv
// rtl/prm_oblgc_sched.sv - arbitrates edge-check requests and walks one code across the checker bank
// Optional PRM_OBLGC_EARLY_EXIT_EN: stop the scan at the first flagged checker.
module prm_oblgc_sched
  import prm_oblgc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_CHK = PRM_NUM_CHK,
  parameter int VEC_W   = PRM_VEC_W,
  parameter int IDX_W   = $clog2(NUM_CHK),
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*VEC_W-1:0] req_vec,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [VEC_W-1:0]         chk_vec,
  output logic [IDX_W-1:0]         chk_idx,
  input  logic                     chk_mask,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_blocked,
  output logic [IDX_W-1:0]         rsp_hit_idx,
  output logic [IDX_W:0]           rsp_hit_cnt,
  output logic                     busy
);

  oblgc_state_e state, state_nxt;

  logic [VEC_W-1:0]   vec_q, sel_vec;
  logic [IDX_W-1:0]   idx_q, hit_idx_q;
  logic [IDX_W:0]     hit_cnt_q;
  logic [ID_W-1:0]    id_q, rr_ptr, gnt_id;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any, arb_en, blocked_q, scan_last;

  // Gating with rst keeps the grant low while reset is held, not just after it.
  assign arb_en = (state == IDLE) && !rst;

  prm_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .en  (arb_en),
    .gnt (gnt),
    .id  (gnt_id),
    .any (gnt_any)
  );

  always_comb begin
    sel_vec = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (gnt[r]) sel_vec = req_vec[r*VEC_W +: VEC_W];
    end
  end

`ifdef PRM_OBLGC_EARLY_EXIT_EN
  assign scan_last = (idx_q == IDX_W'(NUM_CHK - 1)) || chk_mask;
`else
  assign scan_last = (idx_q == IDX_W'(NUM_CHK - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = SCAN;
      SCAN:    if (scan_last) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      vec_q     <= '0;
      id_q      <= '0;
      idx_q     <= '0;
      blocked_q <= 1'b0;
      hit_idx_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            vec_q     <= sel_vec;
            id_q      <= gnt_id;
            idx_q     <= '0;
            blocked_q <= 1'b0;
            hit_idx_q <= '0;
            hit_cnt_q <= '0;
            rr_ptr    <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
          end
        end
        SCAN: begin
          if (chk_mask) begin
            hit_cnt_q <= hit_cnt_q + 1'b1;
            if (!blocked_q) begin
              blocked_q <= 1'b1;
              hit_idx_q <= idx_q;
            end
          end
          if (!scan_last) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = gnt;
  assign chk_vec     = (state == SCAN) ? vec_q : '0;
  assign chk_idx     = (state == SCAN) ? idx_q : '0;
  assign rsp_valid   = (state == RESP);
  assign rsp_id      = id_q;
  assign rsp_blocked = blocked_q;
  assign rsp_hit_idx = hit_idx_q;
  assign rsp_hit_cnt = hit_cnt_q;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_prm_oblgc_sched.sv
// tb/tb_prm_oblgc_sched.sv - scoreboard bench with a behavioural checker-bank and arbitration model
module tb_prm_oblgc_sched;

  localparam int NR = 4;
  localparam int NC = 64;
  localparam int VW = 15;
  localparam int IW = 6;
  localparam int DW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*VW-1:0] req_vec;
  logic [NR-1:0]    req_ready;
  logic [VW-1:0]    chk_vec;
  logic [IW-1:0]    chk_idx;
  logic             chk_mask;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DW-1:0]    rsp_id;
  logic             rsp_blocked;
  logic [IW-1:0]    rsp_hit_idx;
  logic [IW:0]      rsp_hit_cnt;
  logic             busy;

  always #5 clk = ~clk;

  prm_oblgc_sched dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_vec     (req_vec),
    .req_ready   (req_ready),
    .chk_vec     (chk_vec),
    .chk_idx     (chk_idx),
    .chk_mask    (chk_mask),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_blocked (rsp_blocked),
    .rsp_hit_idx (rsp_hit_idx),
    .rsp_hit_cnt (rsp_hit_cnt),
    .busy        (busy)
  );

  // Bank behaviour chosen by the code: none, all, single index, or a scattered pattern.
  function automatic bit bank_fn(logic [VW-1:0] v, logic [IW-1:0] idx);
    int h;
    if (v == 15'h7FFF) return (idx == 6'd5);
    case (v[1:0])
      2'd0:    return 1'b0;
      2'd1:    return 1'b1;
      2'd2:    return (idx == v[7:2]);
      default: begin
        h = int'(v[14:2]) ^ (int'(idx) * 13);
        return (h % 7) == 0;
      end
    endcase
  endfunction

  assign chk_mask = bank_fn(chk_vec, chk_idx);

  typedef struct {
    int id;
    int blocked;
    int hit_idx;
    int hit_cnt;
    int lat;
    int gcyc;
  } exp_t;

  function automatic exp_t model(int id, logic [VW-1:0] v, int gcyc);
    exp_t e;
    e.id = id; e.blocked = 0; e.hit_idx = 0; e.hit_cnt = 0;
    e.gcyc = gcyc; e.lat = gcyc + NC + 1;
    for (int i = 0; i < NC; i++) begin
      if (bank_fn(v, IW'(i))) begin
        if (e.blocked == 0) begin
          e.blocked = 1;
          e.hit_idx = i;
`ifdef PRM_OBLGC_EARLY_EXIT_EN
          e.hit_cnt = 1;
          e.lat = gcyc + i + 2;
          break;
`endif
        end
        e.hit_cnt++;
      end
    end
    return e;
  endfunction

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sbq[$];
  int   grants[$];
  int   gcycs[$];
  bit   inflight = 1'b0;
  bit   in_resp = 1'b0;
  int   ptr_m = 0;
  logic [15:0] snap;
  int   last_id, last_blk, last_idx, last_cnt, last_lat;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [NR-1:0] eg;
    int w;
    int r;
    if (!rst) begin
      chk("busy", busy, inflight);
      eg = '0;
      w  = -1;
      if (!inflight) begin
        for (int k = 0; k < NR; k++) begin
          r = (ptr_m + k) % NR;
          if (w < 0 && req_valid[r]) w = r;
        end
      end
      if (w >= 0) eg[w] = 1'b1;
      chk("req_ready", req_ready, eg);
      if (!inflight) chk("chk_vec_idle", {chk_vec, chk_idx}, 0);

      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          if (!in_resp) begin
            chk("rsp_latency", cyc, sbq[0].lat);
            last_lat = cyc - sbq[0].gcyc;
            in_resp  = 1'b1;
            snap     = {rsp_id, rsp_blocked, rsp_hit_idx, rsp_hit_cnt};
          end else begin
            chk("rsp_hold", {rsp_id, rsp_blocked, rsp_hit_idx, rsp_hit_cnt}, snap);
          end
          if (rsp_ready) begin
            chk("rsp_id", rsp_id, sbq[0].id);
            chk("rsp_blocked", rsp_blocked, sbq[0].blocked);
            chk("rsp_hit_idx", rsp_hit_idx, sbq[0].hit_idx);
            chk("rsp_hit_cnt", rsp_hit_cnt, sbq[0].hit_cnt);
            last_id  = int'(rsp_id);
            last_blk = int'(rsp_blocked);
            last_idx = int'(rsp_hit_idx);
            last_cnt = int'(rsp_hit_cnt);
            void'(sbq.pop_front());
            in_resp  = 1'b0;
            inflight = 1'b0;
          end
        end
      end else if (in_resp) begin
        chk("rsp_valid_dropped", rsp_valid, 1);
      end

      if (w >= 0) begin
        sbq.push_back(model(w, req_vec[w*VW +: VW], cyc));
        inflight = 1'b1;
        ptr_m    = (w + 1) % NR;
        grants.push_back(w);
        gcycs.push_back(cyc);
      end
    end
  end

  task automatic run(int n, int p_new, int p_rdy);
    logic [NR-1:0] g;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      g = req_ready;
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) begin
        if (g[r]) req_valid[r] = 1'b0;
        if (!req_valid[r] && $urandom_range(99) < p_new) begin
          req_valid[r] = 1'b1;
          req_vec[r*VW +: VW] = VW'($urandom);
        end
      end
      rsp_ready = ($urandom_range(99) < p_rdy);
    end
  endtask

  task automatic req1(int r, logic [VW-1:0] v);
    req_valid[r] = 1'b1;
    req_vec[r*VW +: VW] = v;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || inflight || (|req_valid)) && n < 2000) begin
      run(1, 0, 100);
      n++;
    end
    chk("drain_done", n < 2000, 1);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp_fields"}, {rsp_id, rsp_blocked, rsp_hit_idx, rsp_hit_cnt}, 0);
    chk({tag, "_chk_bus"}, {chk_vec, chk_idx}, 0);
  endtask

  initial begin
    int lost;
    rst = 1'b1; req_valid = '0; req_vec = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req_valid = '1;
    #1;
    chk_reset_outputs("reset");
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single request, only checker 5 flags
    req1(2, 15'h7FFF); rsp_ready = 1'b1;
    drain();
    chk("t1_id", last_id, 2);
    chk("t1_blk", last_blk, 1);
    chk("t1_idx", last_idx, 5);
    chk("t1_cnt", last_cnt, 1);
`ifdef PRM_OBLGC_EARLY_EXIT_EN
    chk("t1_lat", last_lat, 7);
`else
    chk("t1_lat", last_lat, 65);
`endif

    // no checker flags
    req1(0, 15'h1230);
    drain();
    chk("t2_blk", last_blk, 0);
    chk("t2_idx", last_idx, 0);
    chk("t2_cnt", last_cnt, 0);
    chk("t2_lat", last_lat, 65);

    // every checker flags
    req1(1, 15'h0005);
    drain();
    chk("t3_blk", last_blk, 1);
    chk("t3_idx", last_idx, 0);
`ifdef PRM_OBLGC_EARLY_EXIT_EN
    chk("t3_cnt", last_cnt, 1);
    chk("t3_lat", last_lat, 2);
`else
    chk("t3_cnt", last_cnt, 64);
    chk("t3_lat", last_lat, 65);
`endif

    // all requesters continuously valid; rotation resumes after requester 1
    grants.delete(); gcycs.delete();
    for (int r = 0; r < NR; r++) req1(r, 15'h0000);
    run(5 * 66 + 4, 100, 100);
    drain();
    chk("t4_ngrants", grants.size() >= 5, 1);
    if (grants.size() >= 5) begin
      chk("t4_g0", grants[0], 2);
      chk("t4_g1", grants[1], 3);
      chk("t4_g2", grants[2], 0);
      chk("t4_g3", grants[3], 1);
      chk("t4_g4", grants[4], 2);
      for (int i = 0; i < 4; i++) chk("t4_period", gcycs[i+1] - gcycs[i], 66);
    end

    // consumer stalls in RESP
    req1(3, 15'h0006); rsp_ready = 1'b0;
    run(80, 0, 0);
    chk("t5_hold_valid", rsp_valid, 1);
    chk("t5_hold_busy", busy, 1);
    chk("t5_hold_noready", req_ready, 0);
    drain();

    // random traffic
    run(3000, 30, 60);
    drain();

    // reset in the middle of a scan
    grants.delete(); gcycs.delete();
    req1(1, 15'h0003); req1(3, 15'h0002); rsp_ready = 1'b1;
    run(21, 0, 100);
    chk("t7_one_grant", grants.size(), 1);
    chk("t7_busy_before", busy, 1);
    lost = (grants.size() > 0) ? grants[0] : 1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midscan");
    sbq.delete(); inflight = 1'b0; in_resp = 1'b0; ptr_m = 0;
    req1(lost, VW'($urandom));
    @(posedge clk);
    #1;
    rst = 1'b0;
    grants.delete(); gcycs.delete();
    drain();
    chk("t7_ngrants", grants.size(), 2);
    if (grants.size() == 2) begin
      chk("t7_g0", grants[0], 1);
      chk("t7_g1", grants[1], 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prm_oblgc_sched.md
# prm_oblgc_sched

Sequencer and arbiter for the PRM obstacle-logic checker bank (the `prm_oblgc_chk*` combinational truth-table modules). It accepts edge-check requests from several planner requesters, then walks one 15-bit joint-configuration code through every checker index, one index per cycle, over a shared muxed `edge_mask` return. It reports per request whether any checker flagged the edge, which checker flagged it first, and how many flagged it.

## Interface
- `NUM_REQ`, 4: number of requesters, at least 1.
- `NUM_CHK`, 64: number of checker instances in the bank, at least 2.
- `VEC_W`, 15: configuration code width, mapping to checker inputs A..O with A as bit 0.
- `IDX_W`, `$clog2(NUM_CHK)`: checker index width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_vec`  in  NUM_REQ*VEC_W  per-requester code; requester r occupies slice [r*VEC_W +: VEC_W].
- `req_ready`  out  NUM_REQ  one-hot grant pulse; at most one bit high per cycle.
- `chk_vec`  out  VEC_W  code driven to every checker input.
- `chk_idx`  out  IDX_W  index the external mux uses to select one checker's `edge_mask`.
- `chk_mask`  in  1  the selected `edge_mask`, combinational from `chk_vec`/`chk_idx`.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  $clog2(NUM_REQ), minimum 1  granted requester.
- `rsp_blocked`  out  1  set when any scanned checker returned 1.
- `rsp_hit_idx`  out  IDX_W  lowest index that returned 1; 0 when nothing was blocked.
- `rsp_hit_cnt`  out  IDX_W+1  number of indices that returned 1.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, SCAN, RESP.
- **IDLE.** When any `req_valid` is high:
  - Round-robin pick, starting from pointer `rr_ptr`.
  - Assert the chosen `req_ready` bit in the same cycle. This is the handshake.
  - Latch `req_vec` slice into `vec_q` and the id into `id_q`.
  - Clear hit state; set `idx_q` to 0.
  - Go to SCAN.
  - Set `rr_ptr` to grant+1, wrapping modulo NUM_REQ.
- **SCAN.**
  - `chk_vec` = `vec_q`; `chk_idx` = `idx_q`.
  - Each cycle, sample `chk_mask`. On 1: increment `hit_cnt`; if this is the first hit, record `hit_idx` = `idx_q`.
  - When `idx_q` = NUM_CHK-1 (with early-exit also on the first hit; see Configuration), go to RESP. Otherwise increment `idx_q`.
- **RESP.**
  - `rsp_valid` is high, and all `rsp_*` fields are stable.
  - On `rsp_valid & rsp_ready`, go to IDLE.
  - No new grant is issued in the same cycle; the next grant comes at the earliest one cycle later.
- Requesters must hold `req_valid`/`req_vec` until granted. Non-granted requests wait; there is no drop.
- Outside SCAN, `chk_vec` and `chk_idx` are driven to 0.

## Timing
- Reset values:
  - FSM = IDLE; `rr_ptr` = 0; `req_ready` = 0; `rsp_valid` = 0; `busy` = 0.
  - All `rsp_*` = 0; `chk_vec` = 0; `chk_idx` = 0.
- Latency, grant at cycle 0:
  - Indices 0..NUM_CHK-1 are scanned in cycles 1..NUM_CHK.
  - `rsp_valid` rises at cycle NUM_CHK+1.
- Throughput: one request per NUM_CHK+2 cycles, given `rsp_ready` held high.
- Boundary cases:
  - Every checker returns 1: `hit_cnt` = NUM_CHK, which fits in IDX_W+1 bits with no saturation needed.
  - `rsp_ready` low: hold in RESP indefinitely with outputs unchanged.
  - Multiple requesters valid at once: strict round-robin gives each one grant per rotation.
  - `rst` asserted mid-SCAN or mid-RESP: immediate return to IDLE with outputs at reset values. The in-flight request is lost and the requester does not re-see a grant.

## Configuration
- `PRM_OBLGC_EARLY_EXIT_EN`
  - **Defined:** SCAN ends on the first hit, going to RESP the next cycle. `rsp_hit_cnt` = 1 when blocked, 0 otherwise. A hit at index k gives `rsp_valid` at cycle k+2.
  - **Undefined:** always a full scan with an exact hit count.

## Structure
- `prm_oblgc_pkg` holds:
  - FSM state enum `oblgc_state_e` {IDLE, SCAN, RESP};
  - `PRM_VEC_W` = 15;
  - the default NUM_CHK constant.
- Sub-module `prm_rr_arb`: parameterised NUM_REQ round-robin arbiter taking request vector, pointer, and enable, and returning one-hot grant plus encoded id.
- Checker bank and index mux are outside this block.

## Test plan
- Single request, id 2, code 0x7FFF, bank model with mask 1 only at index 5, NUM_CHK=64: grant at cycle 0, `rsp_valid` at cycle 65, blocked=1, hit_idx=5, hit_cnt=1, id=2.
- No checker hits: blocked=0, hit_idx=0, hit_cnt=0, latency 65.
- All checkers hit, early-exit off: hit_cnt=64, hit_idx=0. With `PRM_OBLGC_EARLY_EXIT_EN`: `rsp_valid` at cycle 2, hit_cnt=1.
- All 4 requesters valid continuously, `rsp_ready`=1: grant order 0,1,2,3,0, one grant every 66 cycles, never two `req_ready` bits high at once.
- `rsp_ready` held low for 10 cycles in RESP: `rsp_*` stable, no new `req_ready`, `busy`=1.
- `rst` pulsed at scan cycle 20: all outputs at reset values within the same cycle; the pending requester is granted again after `rst` falls.
